// File: rtl/cp0_pkg.sv
// Shared cp0 constants: register addresses ({rd,sel}), exception codes and commit FSM states.
package cp0_pkg;

  localparam logic [7:0] CR_COMPARE = 8'h58;
  localparam logic [7:0] CR_STATUS  = 8'h60;
  localparam logic [7:0] CR_CAUSE   = 8'h68;
  localparam logic [7:0] CR_EPC     = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {StIdle, StFlush} commit_state_e;

  // Writes to these registers can change interrupt pending/enable state.
  function automatic logic is_int_reg(input logic [7:0] addr);
    return (addr == CR_STATUS) || (addr == CR_CAUSE) || (addr == CR_COMPARE);
  endfunction

endpackage

// File: rtl/pms_ex_select.sv
// Combinational priority select among interrupt/exception/eret across two slots (slot1 older),
// producing cp0 event inputs, gated mtc0 enables and the redirect target.
module pms_ex_select
  import cp0_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR = 32'hbfc00380
) (
  input  logic        i_accept,
  input  logic        i_int_ok,
  input  logic        i_s1_valid,
  input  logic        i_s1_ex,
  input  logic [4:0]  i_s1_excode,
  input  logic        i_s1_bd,
  input  logic        i_s1_eret,
  input  logic [31:0] i_s1_pc,
  input  logic [31:0] i_s1_badvaddr,
  input  logic        i_s1_mtc0_we,
  input  logic [7:0]  i_s1_c0_addr,
  input  logic [31:0] i_s1_c0_wdata,
  input  logic        i_s2_valid,
  input  logic        i_s2_ex,
  input  logic [4:0]  i_s2_excode,
  input  logic        i_s2_bd,
  input  logic        i_s2_eret,
  input  logic [31:0] i_s2_pc,
  input  logic [31:0] i_s2_badvaddr,
  input  logic        i_s2_mtc0_we,
  input  logic [7:0]  i_s2_c0_addr,
  input  logic [31:0] i_epc_res,
  output logic        o_pms_ex,
  output logic [4:0]  o_ex_type,
  output logic        o_pms_bd,
  output logic        o_pms_eret,
  output logic [31:0] o_pms_pc,
  output logic [31:0] o_pms_badvaddr,
  output logic        o_inst1_mtc0_we,
  output logic        o_inst2_mtc0_we,
  output logic        o_event,
  output logic [31:0] o_target,
  output logic        o_blk_load
);

  logic w_int, w_s1_ex, w_s1_eret, w_s2_ex, w_s2_eret, w_win1, w_win2;

  assign w_int     = i_int_ok & i_s1_valid;
  assign w_s1_ex   = i_s1_valid & i_s1_ex;
  assign w_s1_eret = i_s1_valid & i_s1_eret;
  assign w_s2_ex   = i_s2_valid & i_s2_ex;
  assign w_s2_eret = i_s2_valid & i_s2_eret;
  assign w_win1    = w_int | w_s1_ex | w_s1_eret;
  assign w_win2    = ~w_win1 & (w_s2_ex | w_s2_eret);

  // A winning slot and everything younger must not commit its mtc0.
  assign o_inst1_mtc0_we = i_accept & i_s1_valid & i_s1_mtc0_we & ~w_win1;
  assign o_inst2_mtc0_we = i_accept & i_s2_valid & i_s2_mtc0_we & ~w_win1 & ~w_win2;
  assign o_event         = i_accept & (w_win1 | w_win2);
  assign o_blk_load      = (o_inst1_mtc0_we & is_int_reg(i_s1_c0_addr)) |
                           (o_inst2_mtc0_we & is_int_reg(i_s2_c0_addr));

  always_comb begin
    o_pms_ex       = 1'b0;
    o_ex_type      = EXC_INT;
    o_pms_bd       = 1'b0;
    o_pms_eret     = 1'b0;
    o_pms_pc       = '0;
    o_pms_badvaddr = '0;
    o_target       = EX_VECTOR;
    if (i_accept) begin
      if (w_int) begin
        o_pms_ex = 1'b1;
        o_pms_pc = i_s1_pc;
        o_pms_bd = i_s1_bd;
      end else if (w_s1_ex) begin
        o_pms_ex       = 1'b1;
        o_ex_type      = i_s1_excode;
        o_pms_pc       = i_s1_pc;
        o_pms_bd       = i_s1_bd;
        o_pms_badvaddr = i_s1_badvaddr;
      end else if (w_s1_eret) begin
        o_pms_eret = 1'b1;
        o_pms_pc   = i_s1_pc;
        o_pms_bd   = i_s1_bd;
        o_target   = i_epc_res;
      end else if (w_s2_ex) begin
        o_pms_ex       = 1'b1;
        o_ex_type      = i_s2_excode;
        o_pms_pc       = i_s2_pc;
        o_pms_bd       = i_s2_bd;
        o_pms_badvaddr = i_s2_badvaddr;
      end else if (w_s2_eret) begin
        o_pms_eret = 1'b1;
        o_pms_pc   = i_s2_pc;
        o_pms_bd   = i_s2_bd;
        // cp0 has not yet seen the older slot's EPC write, so forward it.
        o_target   = (o_inst1_mtc0_we && i_s1_c0_addr == CR_EPC) ? i_s1_c0_wdata : i_epc_res;
      end
    end
  end

endmodule

// File: rtl/pms_ex_commit.sv
// Commit/exception arbiter upstream of cp0: accepts pms bundles, drives cp0 and issues
// flush plus fetch redirect; blocks interrupts briefly after int-relevant mtc0 commits.
module pms_ex_commit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR    = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned INT_BLOCK    = 1
) (
  input  logic        cp0_clk,
  input  logic        reset,
  input  logic        i_bundle_valid,
  output logic        o_bundle_ready,
  input  logic        i_s1_valid,
  input  logic        i_s1_ex,
  input  logic [4:0]  i_s1_excode,
  input  logic        i_s1_bd,
  input  logic        i_s1_eret,
  input  logic [31:0] i_s1_pc,
  input  logic [31:0] i_s1_badvaddr,
  input  logic        i_s1_mtc0_we,
  input  logic [7:0]  i_s1_c0_addr,
  input  logic [31:0] i_s1_c0_wdata,
  input  logic        i_s2_valid,
  input  logic        i_s2_ex,
  input  logic [4:0]  i_s2_excode,
  input  logic        i_s2_bd,
  input  logic        i_s2_eret,
  input  logic [31:0] i_s2_pc,
  input  logic [31:0] i_s2_badvaddr,
  input  logic        i_s2_mtc0_we,
  input  logic [7:0]  i_s2_c0_addr,
  input  logic [31:0] i_s2_c0_wdata,
  input  logic        i_has_int,
  input  logic [31:0] i_epc_res,
  output logic        o_pms_ex,
  output logic [4:0]  o_ex_type,
  output logic        o_pms_bd,
  output logic        o_pms_eret,
  output logic [31:0] o_pms_pc,
  output logic [31:0] o_pms_badvaddr,
  output logic        o_inst1_mtc0_we,
  output logic        o_inst2_mtc0_we,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  commit_state_e r_state;
  logic [2:0]    r_flush_cnt;
  logic [2:0]    r_blk_cnt;
  logic          r_flush, r_redirect_valid;
  logic [31:0]   r_redirect_pc;

  logic          w_accept, w_int_ok, w_event, w_blk_load;
  logic [31:0]   w_target;
  logic [31:0]   w_s2_c0_wdata_unused;

  assign o_bundle_ready       = (r_state == StIdle);
  assign w_accept             = i_bundle_valid & o_bundle_ready;
  assign w_int_ok             = i_has_int & (r_blk_cnt == 3'd0);
  assign o_flush              = r_flush;
  assign o_redirect_valid     = r_redirect_valid;
  assign o_redirect_pc        = r_redirect_pc;
  // The younger slot's data never needs forwarding; cp0 takes it directly.
  assign w_s2_c0_wdata_unused = i_s2_c0_wdata;

  pms_ex_select #(
    .EX_VECTOR(EX_VECTOR)
  ) u_select (
    .i_accept        (w_accept),
    .i_int_ok        (w_int_ok),
    .i_s1_valid      (i_s1_valid),
    .i_s1_ex         (i_s1_ex),
    .i_s1_excode     (i_s1_excode),
    .i_s1_bd         (i_s1_bd),
    .i_s1_eret       (i_s1_eret),
    .i_s1_pc         (i_s1_pc),
    .i_s1_badvaddr   (i_s1_badvaddr),
    .i_s1_mtc0_we    (i_s1_mtc0_we),
    .i_s1_c0_addr    (i_s1_c0_addr),
    .i_s1_c0_wdata   (i_s1_c0_wdata),
    .i_s2_valid      (i_s2_valid),
    .i_s2_ex         (i_s2_ex),
    .i_s2_excode     (i_s2_excode),
    .i_s2_bd         (i_s2_bd),
    .i_s2_eret       (i_s2_eret),
    .i_s2_pc         (i_s2_pc),
    .i_s2_badvaddr   (i_s2_badvaddr),
    .i_s2_mtc0_we    (i_s2_mtc0_we),
    .i_s2_c0_addr    (i_s2_c0_addr),
    .i_epc_res       (i_epc_res),
    .o_pms_ex        (o_pms_ex),
    .o_ex_type       (o_ex_type),
    .o_pms_bd        (o_pms_bd),
    .o_pms_eret      (o_pms_eret),
    .o_pms_pc        (o_pms_pc),
    .o_pms_badvaddr  (o_pms_badvaddr),
    .o_inst1_mtc0_we (o_inst1_mtc0_we),
    .o_inst2_mtc0_we (o_inst2_mtc0_we),
    .o_event         (w_event),
    .o_target        (w_target),
    .o_blk_load      (w_blk_load)
  );

  always_ff @(posedge cp0_clk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush_cnt      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_event) begin
            r_state          <= StFlush;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
            r_flush_cnt      <= 3'(FLUSH_CYCLES - 1);
          end
        end
        StFlush: begin
          r_redirect_valid <= 1'b0;
          if (r_flush_cnt == 3'd0) begin
            r_state <= StIdle;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge cp0_clk) begin
    if (reset) begin
      r_blk_cnt <= '0;
    end else if (w_blk_load) begin
      r_blk_cnt <= 3'(INT_BLOCK);
    end else if (r_blk_cnt != 3'd0) begin
      r_blk_cnt <= r_blk_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_pms_ex_commit.sv
// Directed plus random bench for pms_ex_commit against a cycle-level behavioural model.
module tb_pms_ex_commit;

  localparam logic [31:0] EXV = 32'hbfc00380;
  localparam int FC = 2;
  localparam int IB = 1;

  logic        cp0_clk = 1'b0;
  logic        reset;
  logic        bundle_valid, bundle_ready;
  logic        s1_valid, s1_ex, s1_bd, s1_eret, s1_mtc0_we;
  logic [4:0]  s1_excode;
  logic [31:0] s1_pc, s1_badvaddr, s1_c0_wdata;
  logic [7:0]  s1_c0_addr;
  logic        s2_valid, s2_ex, s2_bd, s2_eret, s2_mtc0_we;
  logic [4:0]  s2_excode;
  logic [31:0] s2_pc, s2_badvaddr, s2_c0_wdata;
  logic [7:0]  s2_c0_addr;
  logic        has_int;
  logic [31:0] epc_res;
  logic        pms_ex, pms_bd, pms_eret, inst1_mtc0_we, inst2_mtc0_we;
  logic [4:0]  ex_type;
  logic [31:0] pms_pc, pms_badvaddr;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;

  // Model state: remaining flush cycles, interrupt-block cycles, redirect registers.
  int          m_busy, m_blk;
  logic        m_rv;
  logic [31:0] m_rpc;

  always #5 cp0_clk = ~cp0_clk;

  pms_ex_commit #(
    .EX_VECTOR(EXV), .FLUSH_CYCLES(FC), .INT_BLOCK(IB)
  ) dut (
    .cp0_clk(cp0_clk), .reset(reset),
    .i_bundle_valid(bundle_valid), .o_bundle_ready(bundle_ready),
    .i_s1_valid(s1_valid), .i_s1_ex(s1_ex), .i_s1_excode(s1_excode), .i_s1_bd(s1_bd),
    .i_s1_eret(s1_eret), .i_s1_pc(s1_pc), .i_s1_badvaddr(s1_badvaddr),
    .i_s1_mtc0_we(s1_mtc0_we), .i_s1_c0_addr(s1_c0_addr), .i_s1_c0_wdata(s1_c0_wdata),
    .i_s2_valid(s2_valid), .i_s2_ex(s2_ex), .i_s2_excode(s2_excode), .i_s2_bd(s2_bd),
    .i_s2_eret(s2_eret), .i_s2_pc(s2_pc), .i_s2_badvaddr(s2_badvaddr),
    .i_s2_mtc0_we(s2_mtc0_we), .i_s2_c0_addr(s2_c0_addr), .i_s2_c0_wdata(s2_c0_wdata),
    .i_has_int(has_int), .i_epc_res(epc_res),
    .o_pms_ex(pms_ex), .o_ex_type(ex_type), .o_pms_bd(pms_bd), .o_pms_eret(pms_eret),
    .o_pms_pc(pms_pc), .o_pms_badvaddr(pms_badvaddr),
    .o_inst1_mtc0_we(inst1_mtc0_we), .o_inst2_mtc0_we(inst2_mtc0_we),
    .o_flush(flush), .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bundle_valid = 0; has_int = 0; epc_res = 32'h0;
    s1_valid = 0; s1_ex = 0; s1_excode = 0; s1_bd = 0; s1_eret = 0; s1_pc = 0;
    s1_badvaddr = 0; s1_mtc0_we = 0; s1_c0_addr = 0; s1_c0_wdata = 0;
    s2_valid = 0; s2_ex = 0; s2_excode = 0; s2_bd = 0; s2_eret = 0; s2_pc = 0;
    s2_badvaddr = 0; s2_mtc0_we = 0; s2_c0_addr = 0; s2_c0_wdata = 0;
  endtask

  // Check one cycle against the model, then clock it and advance the model.
  // Winner codes: 0 none, 1 interrupt, 2 s1 exception, 3 s1 eret, 4 s2 exception, 5 s2 eret.
  task automatic step();
    logic acc, c1, c2;
    int win;
    logic        e_ex, e_eret, e_bd;
    logic [4:0]  e_type;
    logic [31:0] e_pc, e_bva, e_tgt;
    #1;
    chk("bundle_ready", 32'(bundle_ready), 32'(m_busy == 0));
    chk("flush", 32'(flush), 32'(m_busy > 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", redirect_pc, m_rpc);
    acc = bundle_valid && (m_busy == 0);
    win = 0;
    if (acc) begin
      if (has_int && m_blk == 0 && s1_valid) win = 1;
      else if (s1_valid && s1_ex) win = 2;
      else if (s1_valid && s1_eret) win = 3;
      else if (s2_valid && s2_ex) win = 4;
      else if (s2_valid && s2_eret) win = 5;
    end
    c1 = acc && s1_valid && s1_mtc0_we && (win == 0 || win >= 4);
    c2 = acc && s2_valid && s2_mtc0_we && (win == 0);
    e_ex = (win == 1 || win == 2 || win == 4);
    e_eret = (win == 3 || win == 5);
    e_type = (win == 2) ? s1_excode : (win == 4) ? s2_excode : 5'd0;
    e_pc = (win >= 1 && win <= 3) ? s1_pc : (win >= 4) ? s2_pc : 32'h0;
    e_bd = (win >= 1 && win <= 3) ? s1_bd : (win >= 4) ? s2_bd : 1'b0;
    e_bva = (win == 2) ? s1_badvaddr : (win == 4) ? s2_badvaddr : 32'h0;
    e_tgt = EXV;
    if (win == 3) e_tgt = epc_res;
    if (win == 5) e_tgt = (c1 && s1_c0_addr == 8'h70) ? s1_c0_wdata : epc_res;
    chk("pms_ex", 32'(pms_ex), 32'(e_ex));
    chk("pms_eret", 32'(pms_eret), 32'(e_eret));
    chk("ex_type", 32'(ex_type), 32'(e_type));
    chk("pms_pc", pms_pc, e_pc);
    chk("pms_bd", 32'(pms_bd), 32'(e_bd));
    chk("pms_badvaddr", pms_badvaddr, e_bva);
    chk("inst1_mtc0_we", 32'(inst1_mtc0_we), 32'(c1));
    chk("inst2_mtc0_we", 32'(inst2_mtc0_we), 32'(c2));
    @(posedge cp0_clk);
    if (reset) begin
      m_busy = 0; m_blk = 0; m_rv = 0; m_rpc = 0;
    end else begin
      if (win != 0) begin
        m_busy = FC; m_rv = 1; m_rpc = e_tgt;
      end else begin
        if (m_busy > 0) m_busy--;
        m_rv = 0;
      end
      if ((c1 && s1_c0_addr inside {8'h58, 8'h60, 8'h68}) ||
          (c2 && s2_c0_addr inside {8'h58, 8'h60, 8'h68})) m_blk = IB;
      else if (m_blk > 0) m_blk--;
    end
    @(negedge cp0_clk);
  endtask

  initial begin
    logic [7:0] addrs [5];
    addrs = '{8'h58, 8'h60, 8'h68, 8'h70, 8'h00};
    clear_in();
    reset = 1;
    @(posedge cp0_clk);
    @(negedge cp0_clk);
    reset = 0;
    m_busy = 0; m_blk = 0; m_rv = 0; m_rpc = 0;
    step();

    // s1 ADEL beats s2 mtc0 EPC
    bundle_valid = 1; s1_valid = 1; s1_ex = 1; s1_excode = 5'd4; s1_pc = 32'h1000;
    s1_badvaddr = 32'h1003; s2_valid = 1; s2_mtc0_we = 1; s2_c0_addr = 8'h70;
    #1;
    chk("adel_type", 32'(ex_type), 32'd4);
    chk("adel_inst2_we", 32'(inst2_mtc0_we), 32'd0);
    step();
    clear_in();
    chk("adel_rpc", redirect_pc, 32'hbfc00380);
    step(); step(); step();

    // s2 eret with forwarded EPC from s1 mtc0
    bundle_valid = 1; s1_valid = 1; s1_mtc0_we = 1; s1_c0_addr = 8'h70;
    s1_c0_wdata = 32'h2040; s2_valid = 1; s2_eret = 1; epc_res = 32'h9999;
    step();
    clear_in();
    chk("eret_fwd_rpc", redirect_pc, 32'h2040);
    step(); step();

    // interrupt beats s1 SYS; bundle held through flush
    bundle_valid = 1; has_int = 1; s1_valid = 1; s1_ex = 1; s1_excode = 5'd8;
    #1;
    chk("int_type", 32'(ex_type), 32'd0);
    step();
    has_int = 0; s1_ex = 0;
    chk("int_ready_f1", 32'(bundle_ready), 32'd0);
    step();
    chk("int_ready_f2", 32'(bundle_ready), 32'd0);
    step();
    chk("int_ready_back", 32'(bundle_ready), 32'd1);
    clear_in();
    step();

    // STATUS write blocks the interrupt for one cycle
    bundle_valid = 1; s1_valid = 1; s1_mtc0_we = 1; s1_c0_addr = 8'h60;
    step();
    s1_mtc0_we = 0; has_int = 1;
    #1;
    chk("int_blocked", 32'(pms_ex), 32'd0);
    step();
    #1;
    chk("int_unblocked", 32'(pms_ex), 32'd1);
    step();
    clear_in();
    step(); step();

    // s2 OV in delay slot, s1 mtc0 commits
    bundle_valid = 1; s1_valid = 1; s1_mtc0_we = 1; s1_c0_addr = 8'h00;
    s2_valid = 1; s2_ex = 1; s2_excode = 5'd12; s2_bd = 1; s2_pc = 32'h3004;
    #1;
    chk("ov_type", 32'(ex_type), 32'd12);
    chk("ov_inst1_we", 32'(inst1_mtc0_we), 32'd1);
    step();
    clear_in();
    // reset in first flush cycle aborts flush
    reset = 1;
    step();
    reset = 0;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_ready", 32'(bundle_ready), 32'd1);
    step();

    for (int i = 0; i < 400; i++) begin
      bundle_valid = ($urandom_range(3) != 0);
      has_int = ($urandom_range(3) == 0);
      epc_res = $urandom;
      s1_valid = ($urandom_range(4) != 0); s2_valid = ($urandom_range(4) != 0);
      s1_ex = ($urandom_range(7) == 0); s2_ex = ($urandom_range(7) == 0);
      s1_eret = ($urandom_range(9) == 0); s2_eret = ($urandom_range(6) == 0);
      s1_excode = 5'($urandom); s2_excode = 5'($urandom);
      s1_bd = 1'($urandom); s2_bd = 1'($urandom);
      s1_pc = $urandom; s2_pc = $urandom; s1_badvaddr = $urandom; s2_badvaddr = $urandom;
      s1_mtc0_we = 1'($urandom); s2_mtc0_we = 1'($urandom);
      s1_c0_addr = addrs[$urandom_range(4)]; s2_c0_addr = addrs[$urandom_range(4)];
      s1_c0_wdata = $urandom; s2_c0_wdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
